// File: rtl/cache_control_pkg.sv
// Shared types for the LC-3b L1 cache controller: FSM state encoding,
// performance-counter width and a small way-select helper.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } lc3b_cache_state;

    typedef logic [15:0] lc3b_perf_count;

    localparam lc3b_perf_count PERF_COUNT_MAX = 16'hFFFF;

    // One-hot per-way enable for a two-way array.
    function automatic logic [1:0] way_mask(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_control_if.sv
// Bundle between the cache controller, the CPU memory port, the cache
// datapath and physical memory. The controller uses the slave modport.
interface cache_control_if;

    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic       hit0;
    logic       hit1;
    logic       dirty0;
    logic       dirty1;
    logic       lru;
    logic       pmem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic [1:0] load_data;
    logic [1:0] load_tag;
    logic [1:0] load_valid;
    logic [1:0] load_dirty;
    logic       dirty_in;
    logic       load_lru;
    logic       lru_in;
    logic       datain_sel;
    logic       pmem_addr_sel;
    logic       victim_way;

    modport master (
        output mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, load_data, load_tag, load_valid,
               load_dirty, dirty_in, load_lru, lru_in, datain_sel, pmem_addr_sel,
               victim_way
    );

    modport slave (
        input  mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp,
        output mem_resp, pmem_read, pmem_write, load_data, load_tag, load_valid,
               load_dirty, dirty_in, load_lru, lru_in, datain_sel, pmem_addr_sel,
               victim_way
    );

endinterface

// File: rtl/cache_control_sat_counter.sv
// 16-bit event counter that sticks at all-ones; a synchronous clear
// overrides a same-cycle increment.
module sat_counter
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           inc,
    input  logic           clear,
    output lc3b_perf_count count
);

    // NOTE: state is updated only with non-blocking assignments in a block
    // sensitive to both the clock and the reset edge, so the async reset
    // takes effect without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != PERF_COUNT_MAX)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the two-way write-back L1 cache: hit/miss decision,
// array load enables, writeback/fill handshakes and hit/miss counters.
module cache_control
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           reset_n,
    cache_control_if.slave bus,
    input  logic           clear_counts,
    output lc3b_perf_count hit_count,
    output lc3b_perf_count miss_count
);

    lc3b_cache_state state;
    lc3b_cache_state next_state;
    logic            victim_way_q;
    logic            miss_pending;

    logic request;
    logic hit;
    logic hit_way;
    logic victim_dirty;
    logic miss_start;

    assign request      = bus.mem_read | bus.mem_write;
    assign hit          = bus.hit0 | bus.hit1;
    assign hit_way      = ~bus.hit0;
    assign victim_dirty = bus.lru ? bus.dirty1 : bus.dirty0;
    assign miss_start   = (state == IDLE) && request && !hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The victim is frozen at miss time so writeback and fill target the
    // same way even if the datapath's LRU view changes meanwhile.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            victim_way_q <= 1'b0;
            miss_pending <= 1'b0;
        end else begin
            if (miss_start) begin
                victim_way_q <= bus.lru;
                miss_pending <= 1'b1;
            end else if (bus.mem_resp) begin
                miss_pending <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default at the top of the
    // block, so no path through the case can leave one unassigned (latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (miss_start) begin
                    next_state = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) next_state = FILL;
            end
            FILL: begin
                if (bus.pmem_resp) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are held low while reset is asserted, independent of inputs.
    always_comb begin
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.load_data     = 2'b00;
        bus.load_tag      = 2'b00;
        bus.load_valid    = 2'b00;
        bus.load_dirty    = 2'b00;
        bus.dirty_in      = 1'b0;
        bus.load_lru      = 1'b0;
        bus.lru_in        = 1'b0;
        bus.datain_sel    = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (request && hit) begin
                        bus.mem_resp = 1'b1;
                        bus.load_lru = 1'b1;
                        bus.lru_in   = ~hit_way;
                        if (bus.mem_write) begin
                            bus.load_data  = way_mask(hit_way);
                            bus.load_dirty = way_mask(hit_way);
                            bus.dirty_in   = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write    = 1'b1;
                    bus.pmem_addr_sel = 1'b1;
                end
                FILL: begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.load_data  = way_mask(victim_way_q);
                        bus.load_tag   = way_mask(victim_way_q);
                        bus.load_valid = way_mask(victim_way_q);
                        bus.load_dirty = way_mask(victim_way_q);
                        bus.datain_sel = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.victim_way = victim_way_q;

    // Replayed hits after a fill complete the miss and are not counted.
    sat_counter u_hit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (bus.mem_resp & ~miss_pending),
        .clear   (clear_counts),
        .count   (hit_count)
    );

    sat_counter u_miss_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (miss_start),
        .clear   (clear_counts),
        .count   (miss_count)
    );

endmodule
